// File: rtl/regbank_pkg.sv
// Shared constants for the register bank and its write-port arbiter.
package regbank_pkg;

    // Default geometry of the register bank.
    localparam int DEF_ADDRESS_SIZE  = 5;
    localparam int DEF_REGISTER_SIZE = 8;

    // Legal range for the number of writeback requesters.
    localparam int MIN_REQ = 2;
    localparam int MAX_REQ = 8;

    // Width of an index into n requesters, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found when scanning from last+1 upwards, wrapping modulo N.
module rr_arbiter
    import regbank_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]              req,
    input  logic                      enable,
    input  logic [idx_width(N)-1:0]   last,
    output logic [N-1:0]              grant
);

    localparam int IW = idx_width(N);

    logic [IW-1:0] pos;
    logic          found;

    // Rotating priority scan; the most recently granted index is checked last.
    always_comb begin
        grant = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 1; k <= N; k++) begin
            pos = IW'((int'(last) + k) % N);
            if (enable && !found && req[pos]) begin
                grant[pos] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_write_arbiter.sv
// Shares the single write port of register_bank between NUM_REQ writeback
// requesters: round-robin grant, one registered write stage, and
// combinational bypass flags for the bank's two read ports.
//
// Handshake: requester i presents req_valid[i] with stable addr/data until
// the transfer; req_ready[i] is combinational from req_valid, hold and the
// last-grant pointer; a transfer happens on a rising edge where both are 1.
module register_write_arbiter
    import regbank_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int ADDRESS_SIZE  = DEF_ADDRESS_SIZE,
    parameter int REGISTER_SIZE = DEF_REGISTER_SIZE
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               hold,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*ADDRESS_SIZE-1:0]    req_addr,
    input  logic [NUM_REQ*REGISTER_SIZE-1:0]   req_data,
    output logic                               write,
    output logic [ADDRESS_SIZE-1:0]            addr_in,
    output logic [REGISTER_SIZE-1:0]           data_in,
    input  logic [ADDRESS_SIZE-1:0]            addr_out1,
    input  logic [ADDRESS_SIZE-1:0]            addr_out2,
    output logic                               fwd_hit1,
    output logic                               fwd_hit2,
    output logic [idx_width(NUM_REQ)-1:0]      grant_id
);

    localparam int IW = idx_width(NUM_REQ);

    // Last-grant pointer and output write stage.
    logic [IW-1:0]            last_q, last_d;
    logic                     write_q, write_d;
    logic [ADDRESS_SIZE-1:0]  addr_q, addr_d;
    logic [REGISTER_SIZE-1:0] data_q, data_d;
    logic [IW-1:0]            gid_q, gid_d;

    // Arbiter result decoded into an index plus the winner's payload.
    logic [NUM_REQ-1:0]       grant;
    logic                     arb_en;
    logic                     win_valid;
    logic [IW-1:0]            win_idx;
    logic [ADDRESS_SIZE-1:0]  win_addr;
    logic [REGISTER_SIZE-1:0] win_data;

    // Grants are suppressed while stalled or while reset is held low.
    assign arb_en = !hold && reset;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req    (req_valid),
        .enable (arb_en),
        .last   (last_q),
        .grant  (grant)
    );

    // The arbiter only grants valid requesters, so every grant is a transfer.
    assign req_ready = grant;

    // Decode the one-hot grant into an index and select that requester's payload.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        win_addr  = '0;
        win_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_valid = 1'b1;
                win_idx   = IW'(i);
                win_addr  = req_addr[i*ADDRESS_SIZE +: ADDRESS_SIZE];
                win_data  = req_data[i*REGISTER_SIZE +: REGISTER_SIZE];
            end
        end
    end

    // Next state: a transfer loads the write stage for exactly one cycle;
    // otherwise the write pulse drops and the payload holds.
    always_comb begin
        last_d  = last_q;
        write_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        gid_d   = gid_q;
        if (win_valid) begin
            last_d  = win_idx;
            write_d = 1'b1;
            addr_d  = win_addr;
            data_d  = win_data;
            gid_d   = win_idx;
        end
    end

    // State registers; reset drops any in-flight write at once and points
    // last at NUM_REQ-1 so requester 0 has first priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q  <= IW'(NUM_REQ - 1);
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            gid_q   <= '0;
        end else begin
            last_q  <= last_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
        end
    end

    assign write    = write_q;
    assign addr_in  = addr_q;
    assign data_in  = data_q;
    assign grant_id = gid_q;

    // Bypass: a read coinciding with the in-flight write should take data_in.
    assign fwd_hit1 = write_q && (addr_q == addr_out1);
    assign fwd_hit2 = write_q && (addr_q == addr_out2);

endmodule

// File: tb/tb_register_write_arbiter.sv
// Bench for register_write_arbiter with three requesters: directed scenarios
// followed by randomized traffic, compared against a behavioural model.
module tb_register_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            hold;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            write;
    logic [AW-1:0]   addr_in;
    logic [DW-1:0]   data_in;
    logic [AW-1:0]   addr_out1;
    logic [AW-1:0]   addr_out2;
    logic            fwd_hit1;
    logic            fwd_hit2;
    logic [IW-1:0]   grant_id;

    register_write_arbiter #(
        .NUM_REQ       (N),
        .ADDRESS_SIZE  (AW),
        .REGISTER_SIZE (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .write     (write),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .addr_out1 (addr_out1),
        .addr_out2 (addr_out2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .grant_id  (grant_id)
    );

    // Clock and reset: 10 ns period; reset is driven by the main sequence.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of the write port.
    int            last_m;
    bit            exp_write;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    int            exp_gid;
    int            last_winner;

    // Image of the register bank as seen through write/addr_in/data_in.
    logic [DW-1:0] bank_tb [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Round-robin rule: scan last+1, last+2, ... modulo N; first valid wins.
    function automatic int winner(input logic [N-1:0] v, input bit en, input int last);
        int w;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            if (en && w < 0 && v[(last + k) % N]) w = (last + k) % N;
        end
        return w;
    endfunction

    task automatic model_reset();
        last_m    = N - 1;
        exp_write = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
        exp_gid   = 0;
    endtask

    task automatic model_edge(input int w);
        if (w >= 0) begin
            last_m    = w;
            exp_write = 1'b1;
            exp_addr  = req_addr[w*AW +: AW];
            exp_data  = req_data[w*DW +: DW];
            exp_gid   = w;
        end else begin
            exp_write = 1'b0;
        end
        last_winner = w;
    endtask

    // Driver: called at a falling edge with inputs already driven; checks the
    // combinational outputs, advances through one rising edge, then checks
    // the registered outputs at the next falling edge.
    task automatic cycle();
        int w;
        #1;
        w = winner(req_valid, !hold && reset, last_m);
        check("ready", req_ready, (w >= 0) ? (1 << w) : 0);
        check("fwd1", fwd_hit1, exp_write && (exp_addr == addr_out1));
        check("fwd2", fwd_hit2, exp_write && (exp_addr == addr_out2));
        if (write) bank_tb[addr_in] = data_in;
        @(posedge clk);
        model_edge(w);
        @(negedge clk);
        check("write", write, exp_write);
        check("addr_in", addr_in, exp_addr);
        check("data_in", data_in, exp_data);
        check("grant_id", grant_id, exp_gid);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    int            w_manual;
    int            wait_cnt [N];
    bit            h;

    initial begin
        // Reset with every requester valid: nothing may be granted.
        reset     = 1'b0;
        hold      = 1'b0;
        req_valid = '1;
        req_addr  = '0;
        req_data  = '0;
        addr_out1 = '0;
        addr_out2 = '0;
        set_req(0, 5'd1, 8'h11);
        set_req(1, 5'd2, 8'h22);
        set_req(2, 5'd4, 8'h44);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_write", write, 0);
        check("rst_addr", addr_in, 0);
        check("rst_data", data_in, 0);
        check("rst_gid", grant_id, 0);
        @(negedge clk);

        // Release: requester 0 wins the first edge.
        reset = 1'b1;
        cycle();
        check("rst_first_win", last_winner, 0);
        check("rst_first_write", write, 1);
        check("rst_first_addr", addr_in, 5'd1);
        req_valid = '0;
        cycle();

        // Round-robin between requesters 0 and 1 (last is 0, so 1 goes first).
        set_req(0, 5'd3, 8'h30);
        set_req(1, 5'd7, 8'h70);
        req_valid = 3'b011;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("rr_gid", grant_id, (k % 2 == 0) ? 1 : 0);
            check("rr_addr", addr_in, (k % 2 == 0) ? 7 : 3);
        end

        // Hold for three cycles: no grants, write drops after the first edge.
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("hold_write", write, 0);
        end
        hold = 1'b0;
        cycle();
        check("hold_resume_gid", grant_id, 1);
        req_valid = '0;
        cycle();

        // Bypass: write address 5 while the read ports look at 5 and 6.
        set_req(0, 5'd5, 8'hA5);
        addr_out1 = 5'd5;
        addr_out2 = 5'd6;
        req_valid = 3'b001;
        cycle();
        req_valid = '0;
        #1;
        check("byp_hit1", fwd_hit1, 1);
        check("byp_hit2", fwd_hit2, 0);
        check("byp_data", data_in, 8'hA5);
        cycle();
        check("byp_after1", fwd_hit1, 0);
        check("byp_after2", fwd_hit2, 0);

        // Asynchronous reset 3 ns after the edge that raises write.
        set_req(1, 5'd9, 8'h3C);
        req_valid = 3'b010;
        #1;
        w_manual = winner(req_valid, !hold && reset, last_m);
        @(posedge clk);
        model_edge(w_manual);
        #3;
        check("amw_write_pre", write, 1);
        reset = 1'b0;
        #1;
        check("amw_write_drop", write, 0);
        check("amw_fwd_drop", fwd_hit1, 0);
        model_reset();
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("amw_idle", write, 0);
        end

        // Single requester streaming 32 writes, then read the bank image back.
        for (int i = 0; i < 32; i++) bank_tb[i] = 8'hFF;
        for (int i = 0; i < 32; i++) begin
            set_req(1, AW'(i), DW'(i));
            req_valid = 3'b010;
            cycle();
            check("sr_write", write, 1);
        end
        req_valid = '0;
        cycle();
        for (int i = 0; i < 32; i++) check("sr_bank", bank_tb[i], i);

        // Randomized traffic with random hold and bypass addresses.
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 60) begin
                    req_valid[i] = 1'b1;
                    set_req(i, AW'($urandom_range(0, 31)), DW'($urandom_range(0, 255)));
                    wait_cnt[i] = 0;
                end
            end
            hold      = ($urandom_range(0, 99) < 15);
            addr_out1 = $urandom_range(0, 1) ? exp_addr : AW'($urandom_range(0, 31));
            addr_out2 = $urandom_range(0, 1) ? exp_addr : AW'($urandom_range(0, 31));
            h = hold;
            cycle();
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    if (last_winner == i) begin
                        req_valid[i] = 1'b0;
                    end else if (!h) begin
                        wait_cnt[i]++;
                        check("fairness", wait_cnt[i] <= N - 1, 1);
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/register_write_arbiter.md
# register_write_arbiter

Shares the single write port of `register_bank` between `NUM_REQ` writeback requesters (e.g. ALU and load unit).
- Round-robin arbitration; a valid/ready handshake with each requester.
- A registered write stage drives `write`/`addr_in`/`data_in` into the bank.
- Combinational bypass flags for the bank's two read ports, so a read that coincides with the in-flight write can use the new value.
- Sits between the pipeline's writeback logic and `register_bank`.

## Interface
Parameters:
- `NUM_REQ`, 2, number of writeback requesters (2..8)
- `ADDRESS_SIZE`, 5, register address width
- `REGISTER_SIZE`, 8, register data width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `hold`  in  1  pipeline stall; while 1, no new grants
- `req_valid`  in  NUM_REQ  bit i: requester i has a write pending
- `req_ready`  out  NUM_REQ  bit i: requester i granted this cycle
- `req_addr`  in  NUM_REQ*ADDRESS_SIZE  requester i address at bits [i*ADDRESS_SIZE +: ADDRESS_SIZE]
- `req_data`  in  NUM_REQ*REGISTER_SIZE  requester i data, same packing
- `write`  out  1  to bank `write`
- `addr_in`  out  ADDRESS_SIZE  to bank `addr_in`
- `data_in`  out  REGISTER_SIZE  to bank `data_in`
- `addr_out1`, `addr_out2`  in  ADDRESS_SIZE  copies of the bank read addresses
- `fwd_hit1`, `fwd_hit2`  out  1  in-flight write targets read port 1 / 2
- `grant_id`  out  $clog2(NUM_REQ) (min 1)  index of requester owning the current `write`

## Operation
- **Arbitration:** at most one grant per cycle, and only when `hold`=0 and `reset`=1.
  - Search order starts at `last+1` (mod NUM_REQ), where `last` is the most recently granted index.
  - The first `i` with `req_valid[i]`=1 gets `req_ready[i]`=1; all other ready bits are 0.
  - `req_ready` is combinational from `req_valid`, `hold` and `last`.
- **Transfer:** occurs when `req_valid[i]` && `req_ready[i]` at a rising edge.
  - On transfer: `last`←i, `addr_in`←req_addr[i], `data_in`←req_data[i], `grant_id`←i, `write`←1.
  - With no transfer: `write`←0; `addr_in`, `data_in` and `grant_id` hold their values.
- **Requester rule:** once `req_valid` is asserted, it and its addr/data stay stable until the transfer. The block does not check this.
- **Fairness:** a continuously valid requester is granted within NUM_REQ non-hold cycles. Back-to-back transfers from the same requester are allowed only when no other requester is valid.
- **hold:** blocks new grants only. A write already registered still appears on `write` for its one cycle.
- **Bypass:** `fwd_hit1` = `write` && (`addr_in`==`addr_out1`); `fwd_hit2` likewise with `addr_out2`. Both are purely combinational. Forward data is `data_in`.
- **Address 0:** no special treatment; all addresses are arbitrated and written identically.

## Timing
- **Latency:** a transfer at edge N drives `write`=1 during cycle N..N+1. The bank captures it at edge N+1.
- **Write pulse:** exactly one cycle per transfer. Throughput is one write per cycle sustained.
- **Reset (async, `reset`=0):**
  - `write`=0, `addr_in`=0, `data_in`=0, `grant_id`=0, `req_ready`=0.
  - `last`=NUM_REQ-1, so requester 0 has first priority after reset.
- **Reset mid-operation:** the registered write is dropped immediately (`write` falls without waiting for a clock). A requester whose transfer completed in the edge before reset loses that write, and upstream must re-issue. Normal operation resumes on the first rising edge after `reset` returns to 1.
- **Simultaneous valid and hold:** no transfer, and `req_ready` is all 0.
- **Simultaneous requests:** exactly one winner, chosen by the round-robin order; the losers keep `req_valid` high.
- **Pointer wrap-around:** when `last`=NUM_REQ-1, the search starts at 0.

## Structure
- Shared package `regbank_pkg`: default `ADDRESS_SIZE`/`REGISTER_SIZE` constants. `register_bank` uses the same package.
- Sub-module `rr_arbiter` (parameter N): inputs `req`, `enable`, `last`; output one-hot `grant`. Purely combinational.
- The top level holds the `last` pointer, the output register stage and the bypass compares.

## Test plan
- **Reset:** `reset`=0 with all `req_valid`=1 → `req_ready`=0 and `write`=0. Release → requester 0 wins at the first edge, and `write`=1 with its addr/data one cycle later.
- **Round-robin:** NUM_REQ=2, both valid continuously with addrs 3 and 7 → grants alternate 0,1,0,1. Bank sees writes to 3,7,3,7 on consecutive cycles, and `grant_id` alternates.
- **Hold:** both valid and `hold`=1 for 3 cycles → no ready, and `write` falls one cycle after hold rises. Release → arbitration resumes from the saved `last`, with no lost or duplicated write.
- **Bypass:** write addr 5, data 0xA5 while `addr_out1`=5 and `addr_out2`=6 → `fwd_hit1`=1 and `fwd_hit2`=0 during the write cycle only. Both are 0 the following cycle.
- **Async reset mid-write:** assert `reset` 3 ns after the edge that sets `write`=1 → `write`=0 immediately. After release, an idle bank sees no write until a new transfer.
- **Single requester:** only requester 1 valid for 32 cycles, with addr incrementing 0..31 and data=i → 32 consecutive one-cycle writes. Reading the bank back returns data=i at every address.
